// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
//   Shared constants and helpers for the rate-1/2, K=3 hard-decision Viterbi
//   decoder (generators 7 and 5 octal).
//   - MW / TB_LEN   : path-metric width and survivor length
//   - G0 / G1       : generator taps applied to {u, s[1], s[0]}
//   - branch_out()  : encoder output for input u leaving state s
//   - hamming2()    : 2-bit Hamming distance (branch metric, 0..2)
//   - sat_add()     : path metric + branch metric, clamped at 2^MW-1
// -----------------------------------------------------------------------------
package viterbi_pkg;

  localparam int MW         = 4;
  localparam int TB_LEN     = 8;
  localparam int NUM_STATES = 4;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [MW-1:0] metric_t;

  localparam metric_t PM_MAX = '1;

  // Encoder shift register is {u, s[1], s[0]}; each generator is a parity tap.
  function automatic logic [1:0] branch_out(input logic u, input logic [1:0] s);
    logic [2:0] r;
    r = {u, s};
    return {^(r & G0), ^(r & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Metrics are never normalised, so they clamp instead of wrapping.
  function automatic metric_t sat_add(input metric_t pm, input logic [1:0] bm);
    logic [MW:0] sum;
    sum = {1'b0, pm} + {{(MW-1){1'b0}}, bm};
    return sum[MW] ? PM_MAX : sum[MW-1:0];
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// -----------------------------------------------------------------------------
// viterbi_acs
//   Add-compare-select for one trellis state.
//   pm_a/bm_a/surv_a : predecessor {p,0}   (wins ties)
//   pm_b/bm_b/surv_b : predecessor {p,1}
//   pm_out           : saturated winning candidate metric
//   surv_out         : survivor of the winning predecessor (not yet extended)
// -----------------------------------------------------------------------------
module viterbi_acs
  import viterbi_pkg::*;
(
  input  logic [MW-1:0]     pm_a,
  input  logic [MW-1:0]     pm_b,
  input  logic [1:0]        bm_a,
  input  logic [1:0]        bm_b,
  input  logic [TB_LEN-1:0] surv_a,
  input  logic [TB_LEN-1:0] surv_b,
  output logic [MW-1:0]     pm_out,
  output logic [TB_LEN-1:0] surv_out
);

  logic [MW-1:0] cand_a;
  logic [MW-1:0] cand_b;
  logic          pick_b;

  assign cand_a = sat_add(pm_a, bm_a);
  assign cand_b = sat_add(pm_b, bm_b);

  // Strict compare: equal candidates keep the {p,0} predecessor.
  assign pick_b   = (cand_b < cand_a);
  assign pm_out   = pick_b ? cand_b : cand_a;
  assign surv_out = pick_b ? surv_b : surv_a;

endmodule

// File: rtl/viterbi_test.sv
// -----------------------------------------------------------------------------
// viterbi_test
//   Hard-decision Viterbi decoder, rate 1/2, K=3 (7,5 octal), with 8-bit
//   register-exchange survivors. One code symbol is consumed every clock.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (pm0=0, others saturated)
//   data_in    : received symbol, [1] = G0 bit, [0] = G1 bit
//   next       : packed path metrics {pm3, pm2, pm1, pm0}
//   decode_out : survivor of the minimum-metric state, oldest bit at [7]
// -----------------------------------------------------------------------------
module viterbi_test
  import viterbi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  data_in,
  output logic [15:0] next,
  output logic [7:0]  decode_out
);

  logic [MW-1:0]     pm_q     [NUM_STATES];
  logic [MW-1:0]     pm_d     [NUM_STATES];
  logic [TB_LEN-1:0] surv_q   [NUM_STATES];
  logic [TB_LEN-1:0] sel_surv [NUM_STATES];
  logic [TB_LEN-1:0] surv_d   [NUM_STATES];
  logic [TB_LEN-1:0] dec_d;
  logic [TB_LEN-1:0] dec_q;
  logic [MW-1:0]     best_pm;

  // New state ns = {u, p} is reached from {p,0} and {p,1} with input u.
  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_state
    localparam logic       U  = 1'(ns / 2);
    localparam logic [1:0] PA = 2'((ns % 2) * 2);
    localparam logic [1:0] PB = 2'((ns % 2) * 2 + 1);

    logic [1:0] bm_a;
    logic [1:0] bm_b;

    assign bm_a = hamming2(data_in, branch_out(U, PA));
    assign bm_b = hamming2(data_in, branch_out(U, PB));

    viterbi_acs u_acs (
      .pm_a     (pm_q[PA]),
      .pm_b     (pm_q[PB]),
      .bm_a     (bm_a),
      .bm_b     (bm_b),
      .surv_a   (surv_q[PA]),
      .surv_b   (surv_q[PB]),
      .pm_out   (pm_d[ns]),
      .surv_out (sel_surv[ns])
    );

    // Slide the window: drop the oldest decision, append this state's u.
    assign surv_d[ns] = {sel_surv[ns][TB_LEN-2:0], U};
  end

  // Best-state select on the freshly computed metrics; strict '<' keeps the
  // lowest state index on ties.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    best_pm = pm_d[0];
    dec_d   = surv_d[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm_d[s] < best_pm) begin
        best_pm = pm_d[s];
        dec_d   = surv_d[s];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the survivor array is deliberately reset; a new frame must not
      // see decisions from the previous one.
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= PM_MAX;
        surv_q[s] <= '0;
      end
      pm_q[0] <= '0;
      dec_q   <= '0;
    end else begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= pm_d[s];
        surv_q[s] <= surv_d[s];
      end
      dec_q <= dec_d;
    end
  end

  assign next       = {pm_q[3], pm_q[2], pm_q[1], pm_q[0]};
  assign decode_out = dec_q;

endmodule

// File: tb/tb_viterbi_test.sv
// -----------------------------------------------------------------------------
// tb_viterbi_test
//   Directed-vector bench for viterbi_test. The driver issues one symbol per
//   clock and queues the hand-derived {decode_out, next} expected after that
//   symbol's edge; a monitor counts consumed edges and compares.
// -----------------------------------------------------------------------------
module tb_viterbi_test;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  data_in;
  logic [15:0] next;
  logic [7:0]  decode_out;

  always #5 clk = ~clk;

  viterbi_test dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .next       (next),
    .decode_out (decode_out)
  );

  typedef struct {
    int          tag;
    logic [7:0]  dec;
    logic [15:0] nxt;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   issued   = 0;
  int   consumed = 0;

  // Error-free message 10110000 -> codeword 16'hE170.
  logic [1:0]  e170_sym [8] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
  logic [7:0]  e170_dec [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB0};
  logic [15:0] e170_nxt [8] = '{16'hF0F2, 16'h2303, 16'h3032, 16'h0323,
                                16'h2303, 16'h3230, 16'h3230, 16'h3230};

  // Third symbol corrupted 00 -> 01.
  logic [1:0]  err1_sym [8] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
  logic [7:0]  err1_dec [8] = '{8'h01, 8'h02, 8'h04, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB0};
  logic [15:0] err1_nxt [8] = '{16'hF0F2, 16'h2303, 16'h3121, 16'h1232,
                                16'h2313, 16'h3331, 16'h4341, 16'h4341};

  // First symbol 11 -> 10, seventh symbol 00 -> 01.
  logic [1:0]  err2_sym [8] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00};
  logic [7:0]  err2_dec [8] = '{8'h00, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB0};
  logic [15:0] err2_nxt [8] = '{16'hF1F1, 16'h3212, 16'h3132, 16'h1333,
                                16'h3414, 16'h4341, 16'h3242, 16'h3432};

  // Twenty symbols of 11: metrics settle into a slow period-3 climb.
  logic [7:0]  ones_dec [20] = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h24, 8'h49, 8'h92,
                                 8'h24, 8'h49, 8'h92, 8'h24, 8'h49, 8'h92, 8'h24, 8'h49,
                                 8'h92, 8'h24, 8'h49, 8'h92};
  logic [15:0] ones_nxt [20] = '{16'hF0F2, 16'h1214, 16'h2321, 16'h3132, 16'h2223,
                                 16'h3332, 16'h4243, 16'h3334, 16'h4443, 16'h5354,
                                 16'h4445, 16'h5554, 16'h6465, 16'h5556, 16'h6665,
                                 16'h7576, 16'h6667, 16'h7776, 16'h8687, 16'h7778};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one symbol on the falling edge (also releases reset) and queue the
  // response expected after the following rising edge.
  task automatic send(input logic [1:0] sym, input logic [7:0] e_dec,
                      input logic [15:0] e_nxt, input string name);
    @(negedge clk);
    rst_n   = 1'b1;
    data_in = sym;
    issued++;
    sb_q.push_back('{issued, e_dec, e_nxt, name});
  endtask

  task automatic run8(input logic [1:0] sym [8], input logic [7:0] dec [8],
                      input logic [15:0] nxt [8], input string name);
    for (int i = 0; i < 8; i++)
      send(sym[i], dec[i], nxt[i], $sformatf("%s[%0d]", name, i));
  endtask

  // Assert reset between edges and check it takes effect with no clock.
  // With hold set, keep reset low across an edge carrying a non-zero symbol.
  task automatic do_reset(input bit hold, input string name);
    @(posedge clk);
    #2;
    check({name, ".drained"}, 32'(sb_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check({name, ".rst_next"}, {16'h0, next}, 32'h0000FFF0);
    check({name, ".rst_dec"}, {24'h0, decode_out}, 32'h0);
    if (hold) begin
      data_in = 2'b11;
      @(posedge clk);
      #1;
      check({name, ".hold_next"}, {16'h0, next}, 32'h0000FFF0);
      check({name, ".hold_dec"}, {24'h0, decode_out}, 32'h0);
    end
  endtask

  // Monitor: every rising edge with reset released consumes one symbol.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1) consumed++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].tag <= consumed) begin
        e = sb_q.pop_front();
        check({e.name, ".dec"}, {24'h0, decode_out}, {24'h0, e.dec});
        check({e.name, ".next"}, {16'h0, next}, {16'h0, e.nxt});
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : driver
    rst_n   = 1'b1;
    data_in = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("init.next", {16'h0, next}, 32'h0000FFF0);
    check("init.dec", {24'h0, decode_out}, 32'h0);

    for (int i = 0; i < 8; i++)
      send(2'b00, 8'h00, (i == 0) ? 16'hF2F0 : 16'h3230, $sformatf("zero[%0d]", i));

    do_reset(1'b0, "r1");
    run8(e170_sym, e170_dec, e170_nxt, "e170");

    do_reset(1'b0, "r2");
    run8(err1_sym, err1_dec, err1_nxt, "err1");

    do_reset(1'b0, "r3");
    run8(err2_sym, err2_dec, err2_nxt, "err2");

    do_reset(1'b0, "r4");
    for (int i = 0; i < 20; i++)
      send(2'b11, ones_dec[i], ones_nxt[i], $sformatf("ones[%0d]", i));

    do_reset(1'b1, "r5");
    run8(e170_sym, e170_dec, e170_nxt, "e170b");

    @(posedge clk);
    #2;
    check("final.drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_test.md
Name: viterbi_test

Overview:
- Hard-decision Viterbi decoder for a rate-1/2, constraint-length-3 convolutional code (generators 7 and 5, octal).
- Consumes one 2-bit code symbol per clock and updates four path metrics by add-compare-select (ACS).
- Keeps 8-bit register-exchange survivors for each state.
- Continuously presents the survivor of the best state as the decoded byte and exposes the packed path metrics for observation.

Parameters:
- MW, 4, path-metric width in bits; metrics saturate at 2^MW-1.
- TB_LEN, 8, survivor length in bits; equals decode_out width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  2  received code symbol; [1] = G0 (111) bit, [0] = G1 (101) bit.
- next  out  16  packed path metrics {pm3, pm2, pm1, pm0}, MW bits each; pm0 in [3:0].
- decode_out  out  8  survivor of the minimum-metric state; oldest decoded bit at [7], newest at [0].

Behaviour:
- Encoder model:
  - State s = {u[n-1], u[n-2]}, 2 bits.
  - Input u moves the state from s to {u, s[1]}.
  - Branch output is {u^s[1]^s[0], u^s[0]}.
- Branch metric: Hamming distance, 0..2, between data_in and the branch output.
- Reset while rst_n = 0, asynchronous:
  - pm0 = 0; pm1 = pm2 = pm3 = 15 (saturated "infinite").
  - All survivors = 0.
  - next = 16'hFFF0; decode_out = 8'h00.
- Per rising clk edge with rst_n = 1, one symbol is consumed. No valid or handshake signal; every edge counts.
  - For each new state ns = {u, p}, the two predecessors are {p, 0} and {p, 1}.
  - Candidate metric = predecessor pm + branch metric, saturated to 15.
  - Choose the smaller candidate. On a tie, choose predecessor {p, 0}.
  - New survivor = {chosen predecessor survivor[6:0], u}. The oldest bit is discarded, so the window slides indefinitely.
- Outputs are registered and update on the same edge as the metrics, giving 1-cycle latency.
  - decode_out = new survivor of the state with minimum new metric.
  - Ties go to the lowest state index.
- No metric normalisation: metrics saturate at 15, and a new frame requires reset.
- Reset mid-frame discards all history immediately, with no clock needed.
- The value on data_in while rst_n = 0 is ignored.

Decomposition:
- Shared package viterbi_pkg holds:
  - G0 = 3'b111 and G1 = 3'b101.
  - NUM_STATES = 4 and MW.
  - A metric typedef logic [MW-1:0].
  - Function branch_out(u, s).
- Sub-module viterbi_acs, instantiated 4 times. It takes two predecessor metrics, two branch metrics and two survivors, and returns the saturated winning metric and selected survivor.
- The top level holds the registers, the minimum-state select and the output packing.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream -> next = 16'hFFF0 and decode_out = 8'h00 immediately, without waiting for a clock edge.
- All-zero message: 8 symbols 2'b00 after reset -> decode_out = 8'h00, next[3:0] = 0.
- Error-free message 10110000:
  - Feed symbols 11, 10, 00, 01, 01, 11, 00, 00 (codeword 16'hE170), one per edge.
  - Expect decode_out = 8'b10110000 and pm0 = 0.
  - After the 1st edge, expect pm2 = 0 and pm0 = 2.
- Single error: 16'hE170 with the third symbol changed to 01 -> decode_out = 8'b10110000, pm0 = 1.
- Two separated errors: 16'hE170 with symbols 1 and 7 each having one bit flipped -> decode_out = 8'b10110000, pm0 = 2.
- Saturation and sliding window:
  - Feed 20 symbols of 2'b11 -> no metric exceeds 15 and no metric wraps.
  - decode_out holds only the last 8 decisions.
  - Reset, then feed the 16'hE170 sequence -> decode_out = 8'b10110000 again.
